// File: rtl/pps_time_discipline_if.sv
// Filtered timestamp bus feeding the PPS time discipline block.
// Master is the upstream filter; slave is the discipline block.
interface pps_time_discipline_if;
  logic        ts_valid;
  logic [39:0] ts_seconds;
  logic [31:0] ts_subseconds;
  logic [31:0] ts_freq_trim;
  logic        ts_converged;

  modport master (
    output ts_valid,
    output ts_seconds,
    output ts_subseconds,
    output ts_freq_trim,
    output ts_converged
  );

  modport slave (
    input ts_valid,
    input ts_seconds,
    input ts_subseconds,
    input ts_freq_trim,
    input ts_converged
  );
endinterface

// File: rtl/pps_time_discipline.sv
// Local 40.32 time-of-day counter and 1PPS generator disciplined by
// filtered timestamps: step or slew onto the estimate, trim rate, holdover.
module pps_time_discipline #(
  parameter int unsigned CLK_FREQ_HZ      = 100_000_000,
  parameter int unsigned PPS_WIDTH_CYCLES = 10_000_000,
  parameter logic [31:0] STEP_THRESHOLD   = 32'h0010_0000,
  parameter logic [31:0] SLEW_STEP        = 32'd4,
  parameter logic [31:0] HOLDOVER_CYCLES  = 32'd300_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  pps_time_discipline_if.slave ts,
  output logic [39:0] tod_seconds,
  output logic [31:0] tod_subseconds,
  output logic        pps_out,
  output logic [1:0]  sync_state,
  output logic [31:0] phase_error,
  output logic        slew_active,
  output logic [15:0] step_count
);
  localparam logic [64:0] TWO_64   = 65'h1_0000_0000_0000_0000;
  localparam logic [63:0] NOM_INC  = 64'(TWO_64 / 65'(CLK_FREQ_HZ));
  localparam logic [72:0] STEP_TH  = 73'(STEP_THRESHOLD);
  localparam logic [72:0] SLEW_MAX = 73'(SLEW_STEP);
  localparam logic [31:0] PPS_LAST = 32'(PPS_WIDTH_CYCLES - 1);

  typedef enum logic [1:0] {
    UNSYNC   = 2'd0,
    LOCKED   = 2'd1,
    HOLDOVER = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [39:0] sec_q, sec_d;
  logic [63:0] frac_q, frac_d;
  logic [31:0] trim_q, trim_d;
  logic [72:0] rem_q, rem_d;
  logic [71:0] err_q, err_d;
  logic        step_q, step_d;
  logic [31:0] idle_q, idle_d;
  logic [31:0] pw_q, pw_d;
  logic        pps_q, pps_d;
  logic [31:0] perr_q, perr_d;
  logic [15:0] steps_q, steps_d;

  logic        accept;
  logic        do_step;
  logic        applying_step;
  logic [72:0] err;
  logic [72:0] err_abs;
  logic [31:0] err_sat;
  logic [72:0] rem_abs;
  logic [72:0] slew_mag;
  logic [72:0] slew_adj;
  logic [71:0] adj;
  logic [63:0] inc;
  logic [63:0] frac_n;
  logic        c_nat;
  logic [39:0] sec_n;
  logic [71:0] hi_sum;
  logic        fwd_carry;
  logic        pps_trig;

  assign accept  = ts.ts_valid & ts.ts_converged;
  assign err     = {1'b0, ts.ts_seconds, ts.ts_subseconds}
                 - {1'b0, sec_q, frac_q[63:32]};
  assign err_abs = err[72] ? -err : err;
  assign do_step = (state_q == UNSYNC) || (err_abs >= STEP_TH);
  assign applying_step = step_q & ~accept;

  always_comb begin
    err_sat = err[31:0];
    if (!err[72] && (|err[71:31]))
      err_sat = 32'h7FFF_FFFF;
    else if (err[72] && !(&err[71:31]))
      err_sat = 32'h8000_0000;
  end

  assign rem_abs  = rem_q[72] ? -rem_q : rem_q;
  assign slew_mag = (rem_abs > SLEW_MAX) ? SLEW_MAX : rem_abs;
  assign slew_adj = rem_q[72] ? -slew_mag : slew_mag;

  assign inc = NOM_INC + {{32{trim_q[31]}}, trim_q};
  assign {c_nat, frac_n} = {1'b0, frac_q} + {1'b0, inc};
  assign sec_n = sec_q + {39'd0, c_nat};

  // A sample arriving now supersedes both pending step and running slew.
  always_comb begin
    adj = '0;
    if (applying_step)
      adj = err_q;
    else if (!accept)
      adj = slew_adj[71:0];
  end

  assign hi_sum    = {sec_n, frac_n[63:32]} + adj;
  assign fwd_carry = ~accept & ~step_q & ~rem_q[72]
                   & (hi_sum[71:32] != sec_n);
  assign pps_trig  = (state_q != UNSYNC)
                   & ((c_nat & ~applying_step) | fwd_carry);

  always_comb begin
    state_d = state_q;
    sec_d   = hi_sum[71:32];
    frac_d  = {hi_sum[31:0], frac_n[31:0]};
    trim_d  = trim_q;
    rem_d   = rem_q - slew_adj;
    err_d   = err_q;
    step_d  = 1'b0;
    idle_d  = (state_q == LOCKED) ? idle_q + 32'd1 : '0;
    perr_d  = perr_q;
    steps_d = steps_q;
    pps_d   = pps_q;
    pw_d    = pw_q;
    if (applying_step && steps_q != 16'hFFFF)
      steps_d = steps_q + 16'd1;
    if (accept) begin
      state_d = LOCKED;
      trim_d  = ts.ts_freq_trim;
      perr_d  = err_sat;
      idle_d  = '0;
      err_d   = err[71:0];
      step_d  = do_step;
      rem_d   = do_step ? '0 : err;
    end else if (state_q == LOCKED && idle_q == HOLDOVER_CYCLES) begin
      state_d = HOLDOVER;
    end
    if (pps_trig) begin
      pps_d = 1'b1;
      pw_d  = PPS_LAST;
    end else if (pps_q) begin
      if (pw_q == '0)
        pps_d = 1'b0;
      else
        pw_d = pw_q - 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNSYNC;
      sec_q   <= '0;
      frac_q  <= '0;
      trim_q  <= '0;
      rem_q   <= '0;
      err_q   <= '0;
      step_q  <= 1'b0;
      idle_q  <= '0;
      pw_q    <= '0;
      pps_q   <= 1'b0;
      perr_q  <= '0;
      steps_q <= '0;
    end else begin
      state_q <= state_d;
      sec_q   <= sec_d;
      frac_q  <= frac_d;
      trim_q  <= trim_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      step_q  <= step_d;
      idle_q  <= idle_d;
      pw_q    <= pw_d;
      pps_q   <= pps_d;
      perr_q  <= perr_d;
      steps_q <= steps_d;
    end
  end

  assign tod_seconds    = sec_q;
  assign tod_subseconds = frac_q[63:32];
  assign pps_out        = pps_q;
  assign sync_state     = state_q;
  assign phase_error    = perr_q;
  assign slew_active    = |rem_q;
  assign step_count     = steps_q;
endmodule

// File: tb/tb_pps_time_discipline.sv
// Directed bench for pps_time_discipline at CLK_FREQ_HZ=1000,
// PPS width 100 cycles, holdover after 3000 idle cycles.
module tb_pps_time_discipline;
  localparam logic [63:0] NOM = 64'd18446744073709551;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [39:0] tod_seconds;
  logic [31:0] tod_subseconds;
  logic        pps_out;
  logic [1:0]  sync_state;
  logic [31:0] phase_error;
  logic        slew_active;
  logic [15:0] step_count;

  int total = 0;
  int bad = 0;
  logic [15:0] exp_steps = 16'd0;

  always #5 clk = ~clk;

  pps_time_discipline_if ts_if ();

  pps_time_discipline #(
    .CLK_FREQ_HZ     (1000),
    .PPS_WIDTH_CYCLES(100),
    .STEP_THRESHOLD  (32'h0010_0000),
    .SLEW_STEP       (32'd4),
    .HOLDOVER_CYCLES (32'd3000)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ts            (ts_if.slave),
    .tod_seconds   (tod_seconds),
    .tod_subseconds(tod_subseconds),
    .pps_out       (pps_out),
    .sync_state    (sync_state),
    .phase_error   (phase_error),
    .slew_active   (slew_active),
    .step_count    (step_count)
  );

  task automatic drive(input logic [71:0] t, input logic [31:0] trim,
                       input logic conv);
    ts_if.ts_seconds    = t[71:32];
    ts_if.ts_subseconds = t[31:0];
    ts_if.ts_freq_trim  = trim;
    ts_if.ts_converged  = conv;
    ts_if.ts_valid      = 1'b1;
  endtask

  task automatic send_abs(input logic [39:0] s, input logic [31:0] sub,
                          input logic [31:0] trim, input logic conv);
    @(negedge clk);
    drive({s, sub}, trim, conv);
    @(posedge clk);
    #1;
    ts_if.ts_valid = 1'b0;
  endtask

  task automatic send_rel(input logic [71:0] off, input logic [31:0] trim,
                          output logic [71:0] t0);
    @(negedge clk);
    t0 = {tod_seconds, tod_subseconds};
    drive(t0 + off, trim, 1'b1);
    @(posedge clk);
    #1;
    ts_if.ts_valid = 1'b0;
  endtask

  function automatic logic [71:0] adv(input int k);
    logic [127:0] p;
    p = 128'(NOM) * 128'(k);
    return p[103:32];
  endfunction

  task automatic test_reset();
    ts_if.ts_valid = 1'b0;
    ts_if.ts_converged = 1'b0;
    ts_if.ts_seconds = '0;
    ts_if.ts_subseconds = '0;
    ts_if.ts_freq_trim = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({tod_seconds, tod_subseconds} !== 72'd0) begin
      $display("FAIL reset_tod got %h want 0", {tod_seconds, tod_subseconds});
      bad++;
    end
    total++;
    if ({pps_out, sync_state, phase_error, slew_active, step_count} !== '0) begin
      $display("FAIL reset_outs pps=%b st=%0d pe=%h sl=%b sc=%0d want all 0",
               pps_out, sync_state, phase_error, slew_active, step_count);
      bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_free_run();
    repeat (1000) @(posedge clk);
    #1;
    total++;
    if (tod_seconds !== 40'd0) begin
      $display("FAIL freerun_1000 got %0d want 0", tod_seconds);
      bad++;
    end
    @(posedge clk);
    #1;
    total++;
    if (tod_seconds !== 40'd1) begin
      $display("FAIL freerun_1001 got %0d want 1", tod_seconds);
      bad++;
    end
    total++;
    if (pps_out !== 1'b0 || sync_state !== 2'd0) begin
      $display("FAIL freerun_unsync pps=%b st=%0d want 0/0", pps_out, sync_state);
      bad++;
    end
  endtask

  task automatic test_step_lock();
    int cnt;
    send_abs(40'd1000, 32'd0, 32'd0, 1'b1);
    total++;
    if (sync_state !== 2'd1 || phase_error !== 32'h7FFF_FFFF) begin
      $display("FAIL lock_decision st=%0d pe=%h want 1/7fffffff",
               sync_state, phase_error);
      bad++;
    end
    @(posedge clk);
    #1;
    exp_steps++;
    total++;
    if (tod_seconds !== 40'd1000 || step_count !== exp_steps || pps_out !== 1'b0) begin
      $display("FAIL lock_step sec=%0d sc=%0d pps=%b want 1000/%0d/0",
               tod_seconds, step_count, pps_out, exp_steps);
      bad++;
    end
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (tod_seconds != 40'd1000) break;
    end
    total++;
    if (tod_seconds !== 40'd1001 || pps_out !== 1'b1) begin
      $display("FAIL pps_rise sec=%0d pps=%b want 1001/1", tod_seconds, pps_out);
      bad++;
    end
    cnt = 1;
    for (int i = 0; i < 150; i++) begin
      @(posedge clk);
      #1;
      if (pps_out) cnt++;
    end
    total++;
    if (cnt !== 100) begin
      $display("FAIL pps_width got %0d want 100", cnt);
      bad++;
    end
  endtask

  task automatic test_slew();
    logic [71:0] t0;
    logic [71:0] d;
    int cnt;
    send_rel(72'd400, 32'd0, t0);
    total++;
    if (phase_error !== 32'd400) begin
      $display("FAIL slew_phase got %h want 400", phase_error);
      bad++;
    end
    cnt = 0;
    for (int i = 0; i < 130; i++) begin
      if (slew_active) cnt++;
      @(posedge clk);
      #1;
    end
    total++;
    if (cnt !== 100) begin
      $display("FAIL slew_cycles got %0d want 100", cnt);
      bad++;
    end
    d = {tod_seconds, tod_subseconds} - t0 - 72'd400;
    total++;
    if (d !== adv(131) && d !== adv(131) + 72'd1) begin
      $display("FAIL slew_offset got %h want %h(+1)", d, adv(131));
      bad++;
    end
    total++;
    if (step_count !== exp_steps) begin
      $display("FAIL slew_steps got %0d want %0d", step_count, exp_steps);
      bad++;
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    drive({tod_seconds, tod_subseconds} + 72'h20_0000, 32'd0, 1'b1);
    @(negedge clk);
    drive({tod_seconds, tod_subseconds} + 72'd400, 32'd0, 1'b1);
    @(posedge clk);
    #1;
    ts_if.ts_valid = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (step_count !== exp_steps || phase_error !== 32'd400 || slew_active !== 1'b1) begin
      $display("FAIL b2b sc=%0d pe=%h sl=%b want %0d/400/1",
               step_count, phase_error, slew_active, exp_steps);
      bad++;
    end
    repeat (110) @(posedge clk);
    #1;
    total++;
    if (slew_active !== 1'b0) begin
      $display("FAIL b2b_drain got %b want 0", slew_active);
      bad++;
    end
  endtask

  task automatic test_threshold();
    logic [71:0] t0;
    logic [71:0] d;
    send_rel(72'h0F_FFFF, 32'd0, t0);
    @(posedge clk);
    #1;
    total++;
    if (phase_error !== 32'h000F_FFFF || step_count !== exp_steps || slew_active !== 1'b1) begin
      $display("FAIL below_th pe=%h sc=%0d sl=%b want fffff/%0d/1",
               phase_error, step_count, slew_active, exp_steps);
      bad++;
    end
    repeat (5) @(posedge clk);
    send_rel(72'h10_0000, 32'd0, t0);
    @(posedge clk);
    #1;
    exp_steps++;
    total++;
    if (phase_error !== 32'h0010_0000 || step_count !== exp_steps || slew_active !== 1'b0) begin
      $display("FAIL at_th pe=%h sc=%0d sl=%b want 100000/%0d/0",
               phase_error, step_count, slew_active, exp_steps);
      bad++;
    end
    send_rel(72'h20_0000, 32'd0, t0);
    @(posedge clk);
    #1;
    exp_steps++;
    total++;
    if (phase_error !== 32'h0020_0000 || step_count !== exp_steps) begin
      $display("FAIL step_big pe=%h sc=%0d want 200000/%0d",
               phase_error, step_count, exp_steps);
      bad++;
    end
    d = {tod_seconds, tod_subseconds} - t0 - 72'h20_0000;
    total++;
    if (d !== adv(2) && d !== adv(2) + 72'd1) begin
      $display("FAIL step_offset got %h want %h(+1)", d, adv(2));
      bad++;
    end
  endtask

  task automatic test_neg_slew();
    logic [71:0] t0;
    int cnt;
    send_rel(72'd0 - 72'd8, 32'd0, t0);
    total++;
    if (phase_error !== 32'hFFFF_FFF8) begin
      $display("FAIL neg_phase got %h want fffffff8", phase_error);
      bad++;
    end
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      if (slew_active) cnt++;
      @(posedge clk);
      #1;
    end
    total++;
    if (cnt !== 2 || step_count !== exp_steps) begin
      $display("FAIL neg_slew cycles=%0d sc=%0d want 2/%0d", cnt, step_count, exp_steps);
      bad++;
    end
  endtask

  task automatic test_holdover();
    logic [71:0] t0;
    logic prev;
    logic seen;
    send_rel(72'd8, 32'd1000, t0);
    repeat (2998) @(posedge clk);
    #1;
    total++;
    if (sync_state !== 2'd1) begin
      $display("FAIL pre_holdover got %0d want 1", sync_state);
      bad++;
    end
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (sync_state !== 2'd2) begin
      $display("FAIL holdover got %0d want 2", sync_state);
      bad++;
    end
    send_abs(40'd123, 32'd0, 32'd0, 1'b0);
    total++;
    if (sync_state !== 2'd2 || phase_error !== 32'd8) begin
      $display("FAIL unconv_hold st=%0d pe=%h want 2/8", sync_state, phase_error);
      bad++;
    end
    seen = 1'b0;
    prev = pps_out;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (pps_out && !prev) begin
        seen = 1'b1;
        break;
      end
      prev = pps_out;
    end
    total++;
    if (seen !== 1'b1) begin
      $display("FAIL holdover_pps got %b want 1", seen);
      bad++;
    end
    send_rel(72'd8, 32'd0, t0);
    total++;
    if (sync_state !== 2'd1) begin
      $display("FAIL relock got %0d want 1", sync_state);
      bad++;
    end
  endtask

  task automatic test_sat_wrap();
    logic found;
    send_abs(40'd5, 32'd0, 32'd0, 1'b1);
    total++;
    if (phase_error !== 32'h8000_0000) begin
      $display("FAIL sat_neg got %h want 80000000", phase_error);
      bad++;
    end
    @(posedge clk);
    #1;
    exp_steps++;
    total++;
    if (tod_seconds !== 40'd5 || step_count !== exp_steps) begin
      $display("FAIL neg_step sec=%0d sc=%0d want 5/%0d", tod_seconds, step_count, exp_steps);
      bad++;
    end
    send_abs(40'hFF_FFFF_FFFF, 32'hFF00_0000, 32'd0, 1'b1);
    total++;
    if (phase_error !== 32'h7FFF_FFFF) begin
      $display("FAIL sat_pos got %h want 7fffffff", phase_error);
      bad++;
    end
    @(posedge clk);
    #1;
    exp_steps++;
    total++;
    if (tod_seconds !== 40'hFF_FFFF_FFFF || step_count !== exp_steps) begin
      $display("FAIL wrap_step sec=%h sc=%0d want ffffffffff/%0d",
               tod_seconds, step_count, exp_steps);
      bad++;
    end
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (tod_seconds == 40'd0) begin
        found = 1'b1;
        break;
      end
    end
    total++;
    if (found !== 1'b1 || pps_out !== 1'b1) begin
      $display("FAIL wrap_pps wrapped=%b pps=%b want 1/1", found, pps_out);
      bad++;
    end
  endtask

  task automatic test_reset_mid_slew();
    logic [71:0] t0;
    send_rel(72'd400, 32'd0, t0);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total++;
    if ({tod_seconds, tod_subseconds, pps_out, sync_state, phase_error,
         slew_active, step_count} !== '0) begin
      $display("FAIL async_reset sec=%0d sub=%h pps=%b st=%0d pe=%h sl=%b sc=%0d want 0",
               tod_seconds, tod_subseconds, pps_out, sync_state, phase_error,
               slew_active, step_count);
      bad++;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_unconverged();
    send_abs(40'd77, 32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #1;
    total++;
    if (sync_state !== 2'd0 || phase_error !== 32'd0 || step_count !== 16'd0
        || tod_seconds !== 40'd0) begin
      $display("FAIL unconv_unsync st=%0d pe=%h sc=%0d sec=%0d want 0/0/0/0",
               sync_state, phase_error, step_count, tod_seconds);
      bad++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_free_run();
    test_step_lock();
    test_slew();
    test_back_to_back();
    test_threshold();
    test_neg_slew();
    test_holdover();
    test_sat_wrap();
    test_reset_mid_slew();
    test_unconverged();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
